saradc_seq_accum: RTL and testbench

//  Conversion sequencer and oversampling accumulator placed directly downstream of SARADC.
//  It issues GO to SARADC and detects conversion completion on VALID.
//  It captures RESULT, sums 2**OSR_LOG2 conversions, and pushes each sum into a small FIFO.
//  The FIFO output uses a valid/ready interface toward the system bus.

---
 rtl/saradc_seq_accum.sv | 219 +++++++++++++++++++++
 tb/tb_saradc_seq_accum.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/saradc_seq_accum.sv
// Conversion sequencer and oversampling accumulator for a SAR ADC.
// Sums 2**OSR_LOG2 conversions per word and queues the sums in a first-word-fall-through FIFO.
module saradc_seq_accum #(
  parameter int unsigned NBITS      = 5,
  parameter int unsigned OSR_LOG2   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TMO_CYC    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  output logic                          go,
  input  logic                          valid,
  input  logic [NBITS-1:0]              result,
  output logic [NBITS+OSR_LOG2-1:0]     dout,
  output logic                          dvalid,
  input  logic                          dready,
  output logic                          ovf,
  output logic                          tmo,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned DW = NBITS + OSR_LOG2;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
  localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'((1 << OSR_LOG2) - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          valid_q;
  logic          valid_rise;
  logic          capture;
  logic          timeout;

  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sum;
  logic          last;
  logic          push;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;
  logic          ovf_q, ovf_d;
  logic          tmo_q, tmo_d;

  // valid_q resets high so a VALID already high out of reset is not seen as a new edge.
  assign valid_rise = valid & ~valid_q;
  assign capture    = (state_q == CONV) & valid_rise;
  assign timeout    = (state_q == CONV) & ~valid_rise & (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (en && !clr) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (valid_rise) begin
          state_d   = DONE;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      DONE: begin
        if (!valid) begin
          state_d = en ? CONV : IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      valid_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      valid_q   <= valid;
    end
  end

  assign go = (state_q == CONV);

  assign sum  = acc_q + DW'(result);
  assign last = (cnt_q == CNT_LAST);
  assign push = capture & last & ~clr;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (capture) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);
  assign pop   = ~empty & dready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      if (wr && !pop) begin
        level_d = level_q + (AW + 1)'(1);
      end else if (pop && !wr) begin
        level_d = level_q - (AW + 1)'(1);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q | drop;
    tmo_d = tmo_q | timeout;
    if (clr) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr_q] <= sum;
    end
  end

  // Head is forced to zero when empty so stale storage never leaks onto the bus.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem[rptr_q];
    end
  end

  assign dvalid = ~empty;
  assign level  = level_q;
  assign ovf    = ovf_q;
  assign tmo    = tmo_q;

endmodule

// File: tb/tb_saradc_seq_accum.sv
// Bench for saradc_seq_accum: behavioural SAR ADC model, directed sequences and a pop scoreboard.
module tb_saradc_seq_accum;

  localparam int NBITS      = 5;
  localparam int OSR_LOG2   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TMO_CYC    = 64;
  localparam int DW         = NBITS + OSR_LOG2;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT        = 3;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             go;
  logic             valid;
  logic [NBITS-1:0] result;
  logic [DW-1:0]    dout;
  logic             dvalid;
  logic             dready;
  logic             ovf;
  logic             tmo;
  logic [LW-1:0]    level;

  saradc_seq_accum #(
    .NBITS     (NBITS),
    .OSR_LOG2  (OSR_LOG2),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .go    (go),
    .valid (valid),
    .result(result),
    .dout  (dout),
    .dvalid(dvalid),
    .dready(dready),
    .ovf   (ovf),
    .tmo   (tmo),
    .level (level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [NBITS-1:0] res_q[$];
  logic [DW-1:0]    exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ADC model: answers GO after LAT cycles with the next queued result, drops VALID once GO falls.
  initial begin
    int lat;
    lat    = 0;
    valid  = 1'b0;
    result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid = 1'b0;
        lat   = 0;
      end else if (valid) begin
        if (!go) valid = 1'b0;
      end else if (go && res_q.size() > 0) begin
        if (lat >= LAT) begin
          result = res_q.pop_front();
          valid  = 1'b1;
          lat    = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Monitor: samples just before the rising edge, when a handshake is about to complete.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && dvalid && dready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got %0d expected no word", dout);
        end else begin
          check("pop_data", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until the model has handed out every queued result, then stops EN after that capture.
  task automatic run_seq(input bit pop_last);
    en = 1'b1;
    for (int i = 0; i < 2000 && res_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("seq_drained", res_q.size(), 0);
    if (pop_last) dready = 1'b1;
    tick();
    dready = 1'b0;
    en     = 1'b0;
    repeat (6) tick();
  endtask

  task automatic wait_go(input string name);
    for (int i = 0; i < 100 && go !== 1'b1; i++) tick();
    check(name, go, 1);
  endtask

  task automatic drain();
    dready = 1'b1;
    for (int i = 0; i < 50 && level != 0; i++) tick();
    dready = 1'b0;
    check("drain_level", level, 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int c;
    rst_n  = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    dready = 1'b0;
    #1;
    check("rst_go", go, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_dout", dout, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tmo", tmo, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // 3+5+7+9 = 24
    res_q = '{5'd3, 5'd5, 5'd7, 5'd9};
    run_seq(1'b0);
    check("t1_dout", dout, 24);
    check("t1_dvalid", dvalid, 1);
    check("t1_level", level, 1);
    exp_q.push_back(7'd24);
    drain();

    // Words 10, 124, 1, 26, 40: the fifth is dropped
    res_q = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd1,
              5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 5'd10, 5'd10, 5'd10};
    run_seq(1'b0);
    check("t2_level", level, 4);
    check("t2_ovf", ovf, 1);
    check("t2_dout_first", dout, 10);
    check("t2_dvalid", dvalid, 1);
    pulse_clr();
    check("t2_clr_level", level, 0);
    check("t2_clr_ovf", ovf, 0);
    check("t2_clr_dvalid", dvalid, 0);
    check("t2_clr_dout", dout, 0);

    // Timeout: empty model queue, so VALID never rises
    en = 1'b1;
    wait_go("t3_go_rise");
    en = 1'b0;
    c  = 0;
    while (go === 1'b1 && c < 200) begin
      c++;
      tick();
    end
    check("t3_go_cycles", c, TMO_CYC);
    check("t3_tmo", tmo, 1);
    check("t3_level", level, 0);
    repeat (5) tick();
    check("t3_idle_go", go, 0);
    pulse_clr();
    check("t3_clr_tmo", tmo, 0);

    // Full FIFO with a pop in the push cycle: words 4, 8, 12, 16, then 31+30+29+28 = 118
    res_q = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3,
              5'd4, 5'd4, 5'd4, 5'd4, 5'd31, 5'd30, 5'd29, 5'd28};
    exp_q.push_back(7'd4);
    run_seq(1'b1);
    check("t4_level", level, 4);
    check("t4_ovf", ovf, 0);
    check("t4_head", dout, 8);
    exp_q.push_back(7'd8);
    exp_q.push_back(7'd12);
    exp_q.push_back(7'd16);
    exp_q.push_back(7'd118);
    drain();
    check("t4_ovf_after", ovf, 0);

    // Async reset mid-conversion with a partial sum of 14 pending
    res_q = '{5'd7, 5'd7};
    en    = 1'b1;
    for (int i = 0; i < 200 && res_q.size() != 0; i++) tick();
    wait_go("t5_go");
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_go_async", go, 0);
    check("t5_dvalid", dvalid, 0);
    check("t5_dout", dout, 0);
    check("t5_level", level, 0);
    check("t5_ovf", ovf, 0);
    check("t5_tmo", tmo, 0);
    en = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    res_q = '{5'd1, 5'd2, 5'd3, 5'd4};
    run_seq(1'b0);
    check("t5_restart_level", level, 1);
    check("t5_restart_dout", dout, 10);
    exp_q.push_back(7'd10);
    drain();

    // EN dropped during CONV: 6 is still captured and counts toward the next word
    res_q = '{5'd6};
    en    = 1'b1;
    wait_go("t6_go");
    en = 1'b0;
    for (int i = 0; i < 200 && res_q.size() != 0; i++) tick();
    repeat (6) tick();
    c = 0;
    for (int i = 0; i < 10; i++) begin
      if (go === 1'b1) c++;
      tick();
    end
    check("t6_go_low_cycles", c, 0);
    check("t6_level", level, 0);
    res_q = '{5'd1, 5'd2, 5'd3};
    run_seq(1'b0);
    check("t6_level_word", level, 1);
    check("t6_dout", dout, 12);
    exp_q.push_back(7'd12);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
